vga_clk_div_gen: RTL and testbench
==================================

# vga_clk_div_gen

- Parametrised clock generator for the VGA pipeline; successor to the fixed divide-by-4 pixel clock stage.
- Divides `sys_clk` by a runtime-programmable ratio D and produces two outputs:
  - a registered divided clock `clk_out` (near-50 % duty cycle);
  - a one-cycle clock-enable strobe `clk_en` for downstream timing logic.
- Divisor changes are applied glitch-free at a period boundary and tracked by a `div_busy`/`locked` status pair.

## Interface
- `CNT_W`, default 8: counter and divisor width. D is limited to 2 .. 2^CNT_W-1.
- `DEF_DIV`, default 4: divisor loaded at reset. Must be in range 2 .. 2^CNT_W-1.

Ports:
- `sys_clk`  in  1  single system clock; all logic on its rising edge.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  run enable; 0 freezes the divider.
- `restart`  in  1  synchronous phase restart.
- `div_wr`  in  1  divisor write strobe.
- `div_in`  in  CNT_W  divisor value, sampled when `div_wr`=1.
- `clk_out`  out  1  divided clock (registered).
- `clk_en`  out  1  one-cycle strobe coinciding with the first high cycle of `clk_out`.
- `div_busy`  out  1  a written divisor is pending and not yet applied.
- `div_err`  out  1  one-cycle pulse: rejected write.
- `locked`  out  1  one full period has completed at the current divisor.

## Operation
Internal state:
- `cnt` (CNT_W): phase counter, 0..D-1.
- `cur_div`: active divisor D.
- `pend_div`: pending divisor; `div_busy` acts as its valid flag.
- H = D - (D>>1): high-phase length (ceil of D/2). The low phase lasts D>>1 cycles.

Run edge (`en`=1, `restart`=0), all outputs registered:
- `clk_out` <= (`cnt` < H).
- `clk_en` <= (`cnt` == 0).
- `cnt` <= (`cnt` == D-1) ? 0 : `cnt`+1.

Wrap edge (`cnt` == D-1 while running):
- If `div_busy`: `cur_div` <= `pend_div`, `div_busy` <= 0, `locked` <= 0.
- Otherwise: `locked` <= 1.

`en`=0:
- `cnt`, `clk_out`, `cur_div`, `locked` hold.
- `clk_en` <= 0.
- A pending divisor waits for the next wrap.

`restart`=1 (takes priority over `en`):
- `cnt` <= 0, `clk_out` <= 0, `clk_en` <= 0, `locked` <= 0.
- If `div_busy`, the pending divisor is applied immediately.

Divisor writes:
- `div_in` < 2: `div_err` pulses for one cycle; pending and active divisors unchanged.
- Valid write: `pend_div` <= `div_in`, `div_busy` <= 1.
- Write while already busy: last write wins, no error.
- Valid `div_wr` in the same cycle as `restart`: `cur_div` <= `div_in` directly, `div_busy` stays 0.
- Valid `div_wr` in the same cycle as a wrap edge: the new value goes to pending and is applied at the following wrap. The wrap applies the old pending value, if any.

## Timing
- Reset values: `cnt`=0, `cur_div`=DEF_DIV, `pend_div`=0, `clk_out`=0, `clk_en`=0, `div_busy`=0, `div_err`=0, `locked`=0.
- Asserting `sys_rst` mid-operation returns every register to its reset value at the next edge, discarding any pending divisor.
- After reset release with `en`=1, the first edge gives `clk_out`=1 and `clk_en`=1. There is no dead cycle.
- Output period is exactly D `sys_clk` cycles. `clk_en` occurs once per period.
- Odd D: the high phase is one cycle longer than the low phase.
- `div_busy` rises one edge after `div_wr`. It falls on the wrap edge that applies the new value.
- The first `clk_out` period at the new D begins on the edge after the apply.
- `locked` rises D edges after an apply or restart, provided no further apply occurs in between.
- `div_err` rises one edge after the bad `div_wr` and lasts exactly one cycle.

## Test plan
- Reset, `en`=1, DEF_DIV=4 → `clk_out` = 1,1,0,0 repeating; `clk_en` = 1,0,0,0; `locked`=1 after 4 edges.
- Write D=3 at run edge 1 → `div_busy`=1 until the wrap at edge 4. From edge 5 `clk_out` = 1,1,0 repeating; `locked` low at edge 4, high at edge 7.
- Write D=1, then D=0 → `div_err` pulses one cycle each; `cur_div` stays 4; `div_busy` stays 0.
- Write D=6 then D=5 before a wrap → only D=5 applied; no `div_err`.
- `restart` together with `div_wr` D=2 mid-period → next edge `clk_out`=0, `cnt`=0. Then `clk_out` = 1,0 repeating with `clk_en` every 2 cycles.
- `en` low for 3 cycles mid-high-phase → `clk_out` holds 1, `clk_en`=0, `cnt` frozen. The phase resumes without skipping. `sys_rst` asserted mid-period → all outputs 0 on the next edge.

Source files
------------

// File: rtl/vga_clk_div_gen.sv
// Programmable sys_clk divider for the VGA pipeline: registered divided clock,
// one-cycle enable strobe, and glitch-free divisor updates at period boundaries.
module vga_clk_div_gen #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             restart,
  input  logic             div_wr,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk_out,
  output logic             clk_en,
  output logic             div_busy,
  output logic             div_err,
  output logic             locked
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cur_div;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] high_len;
  logic             wrap;
  logic             wr_ok;
  logic             wr_bad;

  // High phase is ceil(D/2), so odd divisors get the extra cycle high.
  assign high_len = cur_div - (cur_div >> 1);
  assign wrap     = (cnt == cur_div - ONE);
  assign wr_ok    = div_wr && (div_in >= MIN_DIV);
  assign wr_bad   = div_wr && (div_in <  MIN_DIV);

  // NOTE: all state updates use non-blocking assignments so every branch reads
  // the pre-edge values; the wrap applies the old pend_div even when a new
  // write overwrites it on the same edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt      <= '0;
      cur_div  <= RST_DIV;
      pend_div <= '0;
      clk_out  <= 1'b0;
      clk_en   <= 1'b0;
      div_busy <= 1'b0;
      div_err  <= 1'b0;
      locked   <= 1'b0;
    end else begin
      div_err <= wr_bad;
      if (restart) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        clk_en  <= 1'b0;
        locked  <= 1'b0;
        // A write arriving with restart bypasses the pending slot entirely.
        if (wr_ok) begin
          cur_div  <= div_in;
          div_busy <= 1'b0;
        end else if (div_busy) begin
          cur_div  <= pend_div;
          div_busy <= 1'b0;
        end
      end else if (en) begin
        clk_out <= (cnt < high_len);
        clk_en  <= (cnt == '0);
        cnt     <= wrap ? '0 : cnt + ONE;
        if (wrap) begin
          if (div_busy) begin
            cur_div  <= pend_div;
            div_busy <= 1'b0;
            locked   <= 1'b0;
          end else begin
            locked <= 1'b1;
          end
        end
        if (wr_ok) begin
          pend_div <= div_in;
          div_busy <= 1'b1;
        end
      end else begin
        clk_en <= 1'b0;
        if (wr_ok) begin
          pend_div <= div_in;
          div_busy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_clk_div_gen.sv
// Scoreboard bench for vga_clk_div_gen: a behavioural model pushes expected
// outputs per edge, and directed scenarios also check literal output patterns.
module tb_vga_clk_div_gen;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       en      = 1'b0;
  logic       restart = 1'b0;
  logic       div_wr  = 1'b0;
  logic [7:0] div_in  = '0;
  logic       clk_out, clk_en, div_busy, div_err, locked;

  vga_clk_div_gen #(.CNT_W(8), .DEF_DIV(4)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (en),
    .restart  (restart),
    .div_wr   (div_wr),
    .div_in   (div_in),
    .clk_out  (clk_out),
    .clk_en   (clk_en),
    .div_busy (div_busy),
    .div_err  (div_err),
    .locked   (locked)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic co;
    logic ce;
    logic bz;
    logic er;
    logic lk;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int   m_cnt, m_div, m_pend;
  logic m_busy;
  exp_t m_out;

  // Observed-output histories for the directed pattern checks (newest in bit 0)
  logic [15:0] seq_co, seq_ce, seq_bz, seq_er, seq_lk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_seq();
    seq_co = '0; seq_ce = '0; seq_bz = '0; seq_er = '0; seq_lk = '0;
  endtask

  task automatic model(input logic r, input logic e, input logic rs, input logic w, input int d);
    logic ok, wrapped;
    int   h;
    if (r) begin
      m_cnt = 0; m_div = 4; m_pend = 0; m_busy = 1'b0;
      m_out = '0;
      return;
    end
    ok       = w && (d >= 2);
    m_out.er = w && (d < 2);
    if (rs) begin
      m_cnt = 0;
      m_out.co = 1'b0; m_out.ce = 1'b0; m_out.lk = 1'b0;
      if (ok) begin
        m_div = d; m_busy = 1'b0;
      end else if (m_busy) begin
        m_div = m_pend; m_busy = 1'b0;
      end
    end else if (e) begin
      h        = m_div - (m_div / 2);
      m_out.co = (m_cnt < h);
      m_out.ce = (m_cnt == 0);
      wrapped  = (m_cnt == m_div - 1);
      m_cnt    = wrapped ? 0 : m_cnt + 1;
      if (wrapped) begin
        if (m_busy) begin
          m_div = m_pend; m_busy = 1'b0; m_out.lk = 1'b0;
        end else begin
          m_out.lk = 1'b1;
        end
      end
      if (ok) begin
        m_pend = d; m_busy = 1'b1;
      end
    end else begin
      m_out.ce = 1'b0;
      if (ok) begin
        m_pend = d; m_busy = 1'b1;
      end
    end
    m_out.bz = m_busy;
  endtask

  task automatic step(input logic r, input logic e, input logic rs, input logic w, input int d);
    exp_t x;
    sys_rst = r; en = e; restart = rs; div_wr = w; div_in = 8'(d);
    model(r, e, rs, w, d);
    sb_q.push_back(m_out);
    @(posedge sys_clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      check("clk_out",  {31'd0, clk_out},  {31'd0, x.co});
      check("clk_en",   {31'd0, clk_en},   {31'd0, x.ce});
      check("div_busy", {31'd0, div_busy}, {31'd0, x.bz});
      check("div_err",  {31'd0, div_err},  {31'd0, x.er});
      check("locked",   {31'd0, locked},   {31'd0, x.lk});
    end
    seq_co = {seq_co[14:0], clk_out};
    seq_ce = {seq_ce[14:0], clk_en};
    seq_bz = {seq_bz[14:0], div_busy};
    seq_er = {seq_er[14:0], div_err};
    seq_lk = {seq_lk[14:0], locked};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("rst_outs", {27'd0, clk_out, clk_en, div_busy, div_err, locked}, 32'd0);
    clr_seq();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_seq();
    @(posedge sys_clk);
    #1;

    // Default divide-by-4 straight out of reset
    do_reset();
    run(8);
    check("a_co", 32'(seq_co), 32'b11001100);
    check("a_ce", 32'(seq_ce), 32'b10001000);
    check("a_lk", 32'(seq_lk), 32'b00011111);

    // Write D=3 on run edge 1; applied at wrap edge 4
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1, 3);
    run(9);
    check("b_co", 32'(seq_co), 32'b1100110110);
    check("b_bz", 32'(seq_bz), 32'b1110000000);
    check("b_lk", 32'(seq_lk), 32'b0000001111);

    // Rejected divisors 1 and 0
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 0);
    run(6);
    check("c_er", 32'(seq_er), 32'b11000000);
    check("c_bz", 32'(seq_bz), 32'b00000000);
    check("c_co", 32'(seq_co), 32'b11001100);

    // Back-to-back writes before a wrap: last one wins
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1, 6);
    step(1'b0, 1'b1, 1'b0, 1'b1, 5);
    run(7);
    check("d_co", 32'(seq_co), 32'b110011100);
    check("d_er", 32'(seq_er), 32'b000000000);

    // Restart with simultaneous D=2 write mid-period
    do_reset();
    run(2);
    clr_seq();
    step(1'b0, 1'b1, 1'b1, 1'b1, 2);
    run(4);
    check("e_co", 32'(seq_co), 32'b01010);
    check("e_ce", 32'(seq_ce), 32'b01010);
    check("e_bz", 32'(seq_bz), 32'b00000);

    // Freeze for three cycles mid-high-phase, then resume, then reset mid-period
    do_reset();
    run(1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    run(4);
    check("f_co", 32'(seq_co), 32'b11111001);
    check("f_ce", 32'(seq_ce), 32'b10000001);
    step(1'b0, 1'b1, 1'b0, 1'b1, 7);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("f_rst", {27'd0, clk_out, clk_en, div_busy, div_err, locked}, 32'd0);
    clr_seq();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9)  != 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 5)  == 0,
           int'($urandom_range(0, 9)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
